// File: rtl/knap_pkg.sv
`default_nettype none
// ============================================================================
// knap_pkg : item table, default sizes and FSM encoding for knap_search
// Revision : 1.0
// ============================================================================
package knap_pkg;

  localparam int N_ITEMS_DEF = 6;
  localparam int SUM_W_DEF   = 8;

  // Index 0 is item A, index 5 is item F
  localparam int ITEM_VALUE  [N_ITEMS_DEF] = '{4, 2, 2, 1, 10, 20};
  localparam int ITEM_WEIGHT [N_ITEMS_DEF] = '{12, 1, 2, 1, 4, 1};
  localparam int ITEM_VOLUME [N_ITEMS_DEF] = '{10, 2, 1, 4, 3, 12};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/knap_search_eval.sv
`default_nettype none
// ============================================================================
// knap_eval : combinational totals and constraint check for one item mask
// Revision  : 1.0
// ============================================================================
module knap_eval
  import knap_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int SUM_W   = SUM_W_DEF
) (
  input  logic [N_ITEMS-1:0] mask,
  input  logic [SUM_W-1:0]   min_value,
  input  logic [SUM_W-1:0]   max_weight,
  input  logic [SUM_W-1:0]   max_volume,
  output logic [SUM_W-1:0]   total_value,
  output logic [SUM_W-1:0]   total_weight,
  output logic [SUM_W-1:0]   total_volume,
  output logic               ok
);

  always_comb begin
    total_value  = '0;
    total_weight = '0;
    total_volume = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        total_value  = total_value  + SUM_W'(ITEM_VALUE[i]);
        total_weight = total_weight + SUM_W'(ITEM_WEIGHT[i]);
        total_volume = total_volume + SUM_W'(ITEM_VOLUME[i]);
      end
    end
    ok = (total_value >= min_value) && (total_weight <= max_weight) &&
         (total_volume <= max_volume);
  end

endmodule
`default_nettype wire

// File: rtl/knap_search.sv
`default_nettype none
// ============================================================================
// knap_search : exhaustive mask enumeration with best-valid-selection tracking
// Revision    : 1.0
// ============================================================================
module knap_search
  import knap_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int SUM_W   = SUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SUM_W-1:0]   min_value,
  input  logic [SUM_W-1:0]   max_weight,
  input  logic [SUM_W-1:0]   max_volume,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [SUM_W-1:0]   best_value,
  output logic [N_ITEMS:0]   valid_count,
  output logic [N_ITEMS-1:0] cand_mask,
  output logic               cand_ok
);

  state_e             state_q, state_d;
  logic [N_ITEMS-1:0] counter_q, counter_d;
  logic [SUM_W-1:0]   min_value_q, min_value_d;
  logic [SUM_W-1:0]   max_weight_q, max_weight_d;
  logic [SUM_W-1:0]   max_volume_q, max_volume_d;

  logic               stage_vld_q, stage_vld_d;
  logic [N_ITEMS-1:0] stage_mask_q, stage_mask_d;
  logic [SUM_W-1:0]   stage_value_q, stage_value_d;
  logic [SUM_W-1:0]   stage_weight_q, stage_weight_d;
  logic               stage_ok_q, stage_ok_d;

  logic               found_q, found_d;
  logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
  logic [SUM_W-1:0]   best_value_q, best_value_d;
  logic [SUM_W-1:0]   best_weight_q, best_weight_d;
  logic [N_ITEMS:0]   valid_count_q, valid_count_d;

  logic [SUM_W-1:0]   eval_value;
  logic [SUM_W-1:0]   eval_weight;
  logic [SUM_W-1:0]   unused_eval_volume;
  logic               eval_ok;

  knap_eval #(
    .N_ITEMS (N_ITEMS),
    .SUM_W   (SUM_W)
  ) u_eval (
    .mask         (counter_q),
    .min_value    (min_value_q),
    .max_weight   (max_weight_q),
    .max_volume   (max_volume_q),
    .total_value  (eval_value),
    .total_weight (eval_weight),
    .total_volume (unused_eval_volume),
    .ok           (eval_ok)
  );

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    min_value_d    = min_value_q;
    max_weight_d   = max_weight_q;
    max_volume_d   = max_volume_q;
    stage_vld_d    = 1'b0;
    stage_mask_d   = stage_mask_q;
    stage_value_d  = stage_value_q;
    stage_weight_d = stage_weight_q;
    stage_ok_d     = stage_ok_q;
    found_d        = found_q;
    best_mask_d    = best_mask_q;
    best_value_d   = best_value_q;
    best_weight_d  = best_weight_q;
    valid_count_d  = valid_count_q;

    // Strict compares keep the earliest (lowest) mask on a full tie
    if (stage_vld_q && stage_ok_q) begin
      valid_count_d = valid_count_q + (N_ITEMS+1)'(1);
      if (!found_q || (stage_value_q > best_value_q) ||
          ((stage_value_q == best_value_q) && (stage_weight_q < best_weight_q))) begin
        found_d       = 1'b1;
        best_mask_d   = stage_mask_q;
        best_value_d  = stage_value_q;
        best_weight_d = stage_weight_q;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          min_value_d   = min_value;
          max_weight_d  = max_weight;
          max_volume_d  = max_volume;
          found_d       = 1'b0;
          best_mask_d   = '0;
          best_value_d  = '0;
          best_weight_d = '0;
          valid_count_d = '0;
          counter_d     = '0;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        stage_vld_d    = 1'b1;
        stage_mask_d   = counter_q;
        stage_value_d  = eval_value;
        stage_weight_d = eval_weight;
        stage_ok_d     = eval_ok;
        if (counter_q == '1) begin
          state_d = ST_DRAIN;
        end else begin
          counter_d = counter_q + N_ITEMS'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      counter_q      <= '0;
      min_value_q    <= '0;
      max_weight_q   <= '0;
      max_volume_q   <= '0;
      stage_vld_q    <= 1'b0;
      stage_mask_q   <= '0;
      stage_value_q  <= '0;
      stage_weight_q <= '0;
      stage_ok_q     <= 1'b0;
      found_q        <= 1'b0;
      best_mask_q    <= '0;
      best_value_q   <= '0;
      best_weight_q  <= '0;
      valid_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      min_value_q    <= min_value_d;
      max_weight_q   <= max_weight_d;
      max_volume_q   <= max_volume_d;
      stage_vld_q    <= stage_vld_d;
      stage_mask_q   <= stage_mask_d;
      stage_value_q  <= stage_value_d;
      stage_weight_q <= stage_weight_d;
      stage_ok_q     <= stage_ok_d;
      found_q        <= found_d;
      best_mask_q    <= best_mask_d;
      best_value_q   <= best_value_d;
      best_weight_q  <= best_weight_d;
      valid_count_q  <= valid_count_d;
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign found       = found_q;
  assign best_mask   = best_mask_q;
  assign best_value  = best_value_q;
  assign valid_count = valid_count_q;
  assign cand_mask   = stage_mask_q;
  assign cand_ok     = stage_ok_q && busy;

endmodule
`default_nettype wire

// File: tb/tb_knap_search.sv
`default_nettype none
// ============================================================================
// tb_knap_search : scoreboard bench for knap_search against a set-level model
// Revision       : 1.0
// ============================================================================
module tb_knap_search;

  localparam int N   = 6;
  localparam int W   = 8;
  localparam int NM  = 1 << N;
  localparam int LAT = NM + 1;

  int val_t [N] = '{4, 2, 2, 1, 10, 20};
  int wgt_t [N] = '{12, 1, 2, 1, 4, 1};
  int vol_t [N] = '{10, 2, 1, 4, 3, 12};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] min_value = '0;
  logic [W-1:0] max_weight = '0;
  logic [W-1:0] max_volume = '0;
  logic         busy, done, found, cand_ok;
  logic [N-1:0] best_mask, cand_mask;
  logic [W-1:0] best_value;
  logic [N:0]   valid_count;

  knap_search #(.N_ITEMS(N), .SUM_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .min_value   (min_value),
    .max_weight  (max_weight),
    .max_volume  (max_volume),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .best_mask   (best_mask),
    .best_value  (best_value),
    .valid_count (valid_count),
    .cand_mask   (cand_mask),
    .cand_ok     (cand_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int found;
    int mask;
    int value;
    int count;
    int acc;
  } exp_t;

  exp_t sb[$];
  int cur_acc  = -1000;
  int cur_min  = 0;
  int cur_maxw = 0;
  int cur_maxv = 0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int item_sum(int sel, int m);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      if (((m >> i) & 1) == 1) begin
        if (sel == 0) s += val_t[i];
        else if (sel == 1) s += wgt_t[i];
        else s += vol_t[i];
      end
    end
    return s;
  endfunction

  function automatic bit ref_ok(int m, int mn, int mw, int mv);
    return (item_sum(0, m) >= mn) && (item_sum(1, m) <= mw) && (item_sum(2, m) <= mv);
  endfunction

  // Best = highest value, then lightest at that value, then lowest mask
  function automatic exp_t ref_run(int mn, int mw, int mv);
    exp_t e;
    int best_v = -1;
    int best_w = 1 << 30;
    bit got = 1'b0;
    e.found = 0; e.mask = 0; e.value = 0; e.count = 0; e.acc = 0;
    for (int m = 0; m < NM; m++) begin
      if (ref_ok(m, mn, mw, mv)) begin
        e.count++;
        if (item_sum(0, m) > best_v) best_v = item_sum(0, m);
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (ref_ok(m, mn, mw, mv) && item_sum(0, m) == best_v && item_sum(1, m) < best_w)
        best_w = item_sum(1, m);
    end
    for (int m = 0; m < NM; m++) begin
      if (!got && ref_ok(m, mn, mw, mv) && item_sum(0, m) == best_v && item_sum(1, m) == best_w) begin
        e.mask = m;
        got = 1'b1;
      end
    end
    if (e.count > 0) begin
      e.found = 1;
      e.value = best_v;
    end
    return e;
  endfunction

  // Monitor: candidate stream each busy cycle, full result on done rising
  logic done_prev = 1'b0;
  exp_t got_e;
  always @(negedge clk) begin
    if (busy && (cyc - cur_acc) >= 1) begin
      check("cand_mask", int'(cand_mask), cyc - cur_acc - 1);
      check("cand_ok", int'(cand_ok), int'(ref_ok(int'(cand_mask), cur_min, cur_maxw, cur_maxv)));
    end
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        got_e = sb.pop_front();
        check("latency", cyc - got_e.acc, LAT);
        check("found", int'(found), got_e.found);
        check("best_mask", int'(best_mask), got_e.mask);
        check("best_value", int'(best_value), got_e.value);
        check("valid_count", int'(valid_count), got_e.count);
        check("busy_at_done", int'(busy), 0);
      end
    end
    done_prev = done;
  end

  // Caller is at a negedge; start is sampled by the following posedge
  task automatic run(input int mn, input int mw, input int mv, input bit expect_it);
    exp_t e;
    min_value  = W'(mn);
    max_weight = W'(mw);
    max_volume = W'(mv);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cur_acc  = cyc;
    cur_min  = mn;
    cur_maxw = mw;
    cur_maxv = mv;
    if (expect_it) begin
      e = ref_run(mn, mw, mv);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_best_mask"}, int'(best_mask), 0);
    check({tag, "_best_value"}, int'(best_value), 0);
    check({tag, "_valid_count"}, int'(valid_count), 0);
    check({tag, "_cand_mask"}, int'(cand_mask), 0);
    check({tag, "_cand_ok"}, int'(cand_ok), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(15, 16, 10, 1'b1); wait_done("s1");
    @(negedge clk); run(0, 63, 63, 1'b1); wait_done("s2");
    @(negedge clk); run(40, 63, 63, 1'b1); wait_done("s3");
    @(negedge clk); run(0, 2, 2, 1'b1); wait_done("s4");

    // Start and new thresholds while running must be ignored
    @(negedge clk); run(15, 16, 10, 1'b1);
    repeat (10) @(negedge clk);
    min_value = 8'd0; max_weight = 8'd63; max_volume = 8'd63; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("s5");

    // One-cycle reset on the 30th edge of a run
    @(negedge clk); run(15, 16, 10, 1'b0);
    while (cyc - cur_acc < 29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midrst_idle");
    run(15, 16, 10, 1'b1); wait_done("s6");

    // Back-to-back from DONE: results cleared at accept
    run(int'($urandom_range(0, 40)), int'($urandom_range(0, 25)), int'($urandom_range(0, 35)), 1'b1);
    @(negedge clk);
    check("b2b_busy", int'(busy), 1);
    check("b2b_done", int'(done), 0);
    check("b2b_found", int'(found), 0);
    check("b2b_valid_count", int'(valid_count), 0);
    check("b2b_best_value", int'(best_value), 0);
    check("b2b_best_mask", int'(best_mask), 0);
    wait_done("b2b");

    for (int k = 0; k < 6; k++) begin
      run(int'($urandom_range(0, 40)), int'($urandom_range(0, 25)), int'($urandom_range(0, 35)), 1'b1);
      wait_done("rnd");
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
